// File: rtl/puf_uart_pkg.sv
// Shared types and constants for the PUF-over-UART command controller.
package puf_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PUF_REQ,
        PUF_WAIT,
        SEND,
        GUARD,
        DRAIN,
        ERR
    } state_t;

    localparam logic [7:0] REPLY_ID       = 8'hA5;
    localparam logic [7:0] REPLY_ERR      = 8'hEE;
    localparam logic [3:0] FRAME_LEN      = 4'd8;
    localparam logic [3:0] FRAME_LEN_CSUM = 4'd9;

    // Byte k of a response word, MSB first (k = 0 -> bits 63:56).
    function automatic logic [7:0] resp_byte(input logic [63:0] w, input logic [3:0] k);
        logic [63:0] s;
        s = w << {k[2:0], 3'b000};
        return s[63:56];
    endfunction

endpackage

// File: rtl/puf_timeout_ctr.sv
// Purpose: counts cycles while enabled; expired is high on the TIMEOUT_CYCLES-th enabled cycle.
// Latency: expired is combinational from the count; clear takes effect on the next edge.
// Backpressure: none; the counter holds at its last value once expired.
module puf_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && cnt != LAST) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/puf_uart_ctrl.sv
// Purpose: UART command decoder that triggers PUF reads and streams replies; FRAME_CHECKSUM_EN adds an XOR byte.
// Latency: 1 cycle rx_valid->puf_start, 1 cycle puf_done->first tx_start.
// Backpressure: each byte waits for tx_busy low; commands arriving while busy are dropped.
module puf_uart_ctrl
    import puf_uart_pkg::*;
#(
    parameter logic [7:0] CMD_READ       = 8'h52,
    parameter logic [7:0] CMD_ID         = 8'h49,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_error,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        puf_start,
    input  logic        puf_done,
    input  logic [63:0] puf_response,
    output logic        busy,
    output logic [7:0]  err_count
);
    state_t      state;
    logic [63:0] resp_buf;
    logic [3:0]  idx;
    logic [3:0]  last_idx;
    logic [3:0]  idx_nxt;
    logic [7:0]  next_byte;
    logic        tmo_expired;
    logic        timeout_evt;
    logic [8:0]  err_sum;

    puf_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == PUF_REQ),
        .enable  (state == PUF_WAIT),
        .expired (tmo_expired)
    );

    // puf_done in the expiry cycle wins, so it is not a timeout.
    assign timeout_evt = tmo_expired && !puf_done;
    assign tx_start    = (state == SEND) && !tx_busy;
    assign busy        = (state != IDLE);
    assign idx_nxt     = idx + 4'd1;
    assign err_sum     = {1'b0, err_count} + {8'b0, rx_error} + {8'b0, timeout_evt};

`ifdef FRAME_CHECKSUM_EN
    logic [7:0] csum;
    always_comb begin
        csum = 8'h00;
        for (int k = 0; k < 8; k++) csum = csum ^ resp_buf[8*k +: 8];
    end
    always_comb begin
        next_byte = resp_byte(resp_buf, idx_nxt);
        if (idx_nxt == FRAME_LEN) next_byte = csum;
    end
    localparam logic [3:0] PUF_LAST = FRAME_LEN_CSUM - 4'd1;
`else
    assign next_byte = resp_byte(resp_buf, idx_nxt);
    localparam logic [3:0] PUF_LAST = FRAME_LEN - 4'd1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tx_data   <= 8'h00;
            puf_start <= 1'b0;
            err_count <= 8'h00;
            resp_buf  <= 64'h0;
            idx       <= 4'd0;
            last_idx  <= 4'd0;
        end else begin
            err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
            puf_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_valid && rx_data == CMD_READ) begin
                        puf_start <= 1'b1;
                        state     <= PUF_REQ;
                    end else if (rx_valid && rx_data == CMD_ID) begin
                        resp_buf <= {REPLY_ID, 56'h0};
                        tx_data  <= REPLY_ID;
                        idx      <= 4'd0;
                        last_idx <= 4'd0;
                        state    <= SEND;
                    end
                end
                PUF_REQ: state <= PUF_WAIT;
                PUF_WAIT: begin
                    if (puf_done) begin
                        resp_buf <= puf_response;
                        tx_data  <= puf_response[63:56];
                        idx      <= 4'd0;
                        last_idx <= PUF_LAST;
                        state    <= SEND;
                    end else if (tmo_expired) begin
                        state <= ERR;
                    end
                end
                SEND: if (!tx_busy) state <= GUARD;
                GUARD: state <= DRAIN;
                DRAIN: begin
                    if (!tx_busy) begin
                        if (idx == last_idx) begin
                            state <= IDLE;
                        end else begin
                            idx     <= idx_nxt;
                            tx_data <= next_byte;
                            state   <= SEND;
                        end
                    end
                end
                ERR: begin
                    resp_buf <= {REPLY_ERR, 56'h0};
                    tx_data  <= REPLY_ERR;
                    idx      <= 4'd0;
                    last_idx <= 4'd0;
                    state    <= SEND;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_uart_ctrl.sv
// Bench for puf_uart_ctrl: random PUF words, delays and UART busy times against a byte-list reference model.
module tb_puf_uart_ctrl;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_error = 1'b0;
    logic        tx_busy = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        puf_start;
    logic        puf_done = 1'b0;
    logic [63:0] puf_response = 64'h0;
    logic        busy;
    logic [7:0]  err_count;

    puf_uart_ctrl #(.CMD_READ(8'h52), .CMD_ID(8'h49), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_error(rx_error),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data), .puf_start(puf_start),
        .puf_done(puf_done), .puf_response(puf_response), .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int rx_cyc, done_cyc, puf_start_cyc;
    int puf_start_cnt = 0;
    int puf_delay = 0;
    int busy_hold = 0;
    int exp_err = 0;
    logic [63:0] resp_word = 64'h0;
    logic prev_start = 1'b0;
    logic [7:0] got[$];
    int start_cyc[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b; rx_cyc = cyc;
        step(1);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin step(1); n++; end
        check({tag, "_timeout"}, 64'(n >= budget), 64'd0);
    endtask

    function automatic int sat_add(input int a, input int b);
        return (a + b > 255) ? 255 : a + b;
    endfunction

    task automatic check_frame(input string tag, input logic [7:0] exp_q[$]);
        check({tag, "_nbytes"}, 64'(got.size()), 64'(exp_q.size()));
        foreach (exp_q[i])
            check($sformatf("%s_byte%0d", tag, i), (i < got.size()) ? 64'(got[i]) : 64'hx, 64'(exp_q[i]));
    endtask

    // Reference frame: 8 response bytes MSB first, plus XOR byte when checksum is built in.
    task automatic read_frame(input string tag, input logic [63:0] w, input int delay, input int hold);
        logic [7:0] exp_q[$];
        logic [7:0] x = 8'h00;
        int n0 = puf_start_cnt;
        resp_word = w; puf_delay = delay; busy_hold = hold;
        got.delete(); start_cyc.delete();
        send_byte(8'h52);
        wait_idle(tag, 3000);
        check({tag, "_puf_starts"}, 64'(puf_start_cnt - n0), 64'd1);
        check({tag, "_puf_lat"}, 64'(puf_start_cyc - rx_cyc), 64'd1);
        if (delay >= 0 && delay < TMO) begin
            for (int k = 0; k < 8; k++) begin
                exp_q.push_back(w[63 - 8*k -: 8]);
                x = x ^ w[63 - 8*k -: 8];
            end
`ifdef FRAME_CHECKSUM_EN
            exp_q.push_back(x);
`endif
            check({tag, "_tx_lat"}, (start_cyc.size() > 0) ? 64'(start_cyc[0] - done_cyc) : 64'hx, 64'd1);
        end else begin
            exp_q.push_back(8'hEE);
            exp_err = sat_add(exp_err, 1);
        end
        check_frame(tag, exp_q);
        check({tag, "_err_count"}, 64'(err_count), 64'(exp_err));
    endtask

    // UART transmitter and PUF models.
    initial begin
        int pend = -1;
        int hold = 0;
        logic st, ps;
        forever begin
            @(negedge clk);
            st = tx_start; ps = puf_start;
            if (st) begin
                check("tx_start_spacing", 64'(prev_start), 64'd0);
                got.push_back(tx_data);
                start_cyc.push_back(cyc);
            end
            prev_start = st;
            if (ps) begin puf_start_cnt++; puf_start_cyc = cyc; pend = puf_delay; end
            @(posedge clk); #1;
            if (rst) begin pend = -1; hold = 0; end
            if (st) hold = busy_hold;
            if (hold > 0) begin tx_busy = 1'b1; hold--; end else tx_busy = 1'b0;
            if (pend == 0) begin
                puf_done = 1'b1; puf_response = resp_word; done_cyc = cyc; pend = -1;
            end else begin
                puf_done = 1'b0;
                if (pend > 0) pend--;
            end
        end
    end

    initial begin
        forever begin @(posedge clk); cyc++; end
    end

    initial begin
        logic [7:0] b;
        logic [7:0] one_q[$];
        int n;
        // Reset values
        #2 rst = 1'b1;
        #1;
        check("rst_tx_start", 64'(tx_start), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_puf_start", 64'(puf_start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        step(3);
        rst = 1'b0;
        step(2);

        // ID reply
        busy_hold = 3; got.delete();
        send_byte(8'h49);
        wait_idle("id", 200);
        one_q = '{8'hA5};
        check_frame("id", one_q);
        check("id_busy_after", 64'(busy), 64'd0);

        // Unknown bytes are ignored in IDLE
        for (int i = 0; i < 4; i++) begin
            do b = 8'($urandom); while (b == 8'h52 || b == 8'h49);
            got.delete();
            send_byte(b);
            step(3);
            check($sformatf("ignore_%0h_busy", b), 64'(busy), 64'd0);
            check($sformatf("ignore_%0h_tx", b), 64'(got.size()), 64'd0);
        end

        // Directed frame, then randomized frames
        read_frame("fixed", 64'h0123456789ABCDEF, 0, 0);
        for (int i = 0; i < 5; i++)
            read_frame($sformatf("rand%0d", i), {$urandom, $urandom}, $urandom_range(0, 12), $urandom_range(0, 6));

        // Timeout boundary: done on the last allowed cycle wins, one later is too late
        read_frame("done_at_limit", {$urandom, $urandom}, TMO - 1, 0);
        read_frame("done_late", {$urandom, $urandom}, TMO, 0);
        read_frame("no_done", 64'h0, -1, 2);

        // Timeout coinciding with rx_error counts twice
        puf_delay = -1; busy_hold = 0; got.delete();
        send_byte(8'h52);
        step(TMO);
        rx_error = 1'b1;
        step(1);
        rx_error = 1'b0;
        wait_idle("tmo_rxerr", 300);
        exp_err = sat_add(exp_err, 2);
        one_q = '{8'hEE};
        check_frame("tmo_rxerr", one_q);
        check("tmo_rxerr_err_count", 64'(err_count), 64'(exp_err));

        // Long tx_busy with a command injected mid-frame
        resp_word = {$urandom, $urandom}; puf_delay = 2; busy_hold = 100;
        got.delete(); n = puf_start_cnt;
        send_byte(8'h52);
        step(300);
        send_byte(8'h52);
        send_byte(8'h49);
        wait_idle("slow", 3000);
        check("slow_puf_starts", 64'(puf_start_cnt - n), 64'd1);
        check("slow_nbytes", 64'(got.size()),
`ifdef FRAME_CHECKSUM_EN
              64'd9);
`else
              64'd8);
`endif
        for (int k = 0; k < 8; k++)
            check($sformatf("slow_byte%0d", k), (k < got.size()) ? 64'(got[k]) : 64'hx, 64'(resp_word[63 - 8*k -: 8]));

        // Asynchronous reset after byte 3
        resp_word = {$urandom, $urandom}; puf_delay = 1; busy_hold = 10; got.delete();
        send_byte(8'h52);
        n = 0;
        while (got.size() < 3 && n < 500) begin step(1); n++; end
        check("midrst_reach_byte3", 64'(got.size()), 64'd3);
        #2 rst = 1'b1;
        #1;
        check("midrst_tx_start", 64'(tx_start), 64'd0);
        check("midrst_tx_data", 64'(tx_data), 64'd0);
        check("midrst_puf_start", 64'(puf_start), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_err_count", 64'(err_count), 64'd0);
        exp_err = 0;
        step(2);
        rst = 1'b0;
        got.delete();
        step(50);
        check("postrst_no_tx", 64'(got.size()), 64'd0);
        check("postrst_busy", 64'(busy), 64'd0);

        // rx_error counting and saturation
        for (int i = 0; i < 5; i++) begin
            rx_error = 1'b1; step(1); rx_error = 1'b0; step(1);
            exp_err = sat_add(exp_err, 1);
        end
        check("rxerr_count", 64'(err_count), 64'(exp_err));
        for (int i = 0; i < 260; i++) begin
            rx_error = 1'b1; step(1);
            exp_err = sat_add(exp_err, 1);
        end
        rx_error = 1'b0; step(1);
        check("err_saturate", 64'(err_count), 64'(exp_err));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
